// File: rtl/conv_pass_scheduler_if.sv
// rtl/conv_pass_scheduler_if.sv - handshake bundle between layer FSM, conv datapath and the pass scheduler
interface conv_pass_scheduler_if #(
    parameter int PIX_W       = 12,
    parameter int PASS_W      = 8,
    parameter int SCALE_WIDTH = 4
);
    logic                   start;
    logic [PIX_W-1:0]       cfg_pixels;
    logic [PASS_W-1:0]      cfg_passes;
    logic [SCALE_WIDTH-1:0] cfg_scale;
    logic                   wgt_req;
    logic                   wgt_ack;
    logic                   data_req;
    logic                   data_valid_in;
    logic                   adder_rst;
    logic [SCALE_WIDTH-1:0] scale_out;
    logic                   last_pass;
    logic [PASS_W-1:0]      pass_idx;
    logic                   busy;
    logic                   state_end;

    modport master (
        output start, cfg_pixels, cfg_passes, cfg_scale, wgt_ack, data_valid_in,
        input  wgt_req, data_req, adder_rst, scale_out, last_pass, pass_idx, busy, state_end
    );

    modport slave (
        input  start, cfg_pixels, cfg_passes, cfg_scale, wgt_ack, data_valid_in,
        output wgt_req, data_req, adder_rst, scale_out, last_pass, pass_idx, busy, state_end
    );
endinterface

// File: rtl/conv_pass_scheduler.sv
// rtl/conv_pass_scheduler.sv - sequences weight-load / pixel-stream passes of one conv job through the MAC array
module conv_pass_scheduler #(
    parameter int PIX_W        = 12,
    parameter int PASS_W       = 8,
    parameter int SCALE_WIDTH  = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    conv_pass_scheduler_if.slave  sif
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PIX_W-1:0]       pix_cnt;
    logic [PIX_W-1:0]       pix_cnt_nxt;
    logic [PIX_W-1:0]       lat_pixels;
    logic [PIX_W-1:0]       lat_pixels_nxt;
    logic [PASS_W-1:0]      pass_idx;
    logic [PASS_W-1:0]      pass_idx_nxt;
    logic [PASS_W-1:0]      lat_passes;
    logic [PASS_W-1:0]      lat_passes_nxt;
    logic [SCALE_WIDTH-1:0] scale_q;
    logic [SCALE_WIDTH-1:0] scale_nxt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [DRAIN_W-1:0]     drain_cnt_nxt;
    logic                   wgt_req_q;
    logic                   data_req_q;

    logic pix_accept;
    logic pix_last;
    logic pass_last;

    assign pix_accept = (state == STREAM) && sif.data_valid_in;
    assign pix_last   = (pix_cnt == (lat_pixels - PIX_W'(1)));
    assign pass_last  = (pass_idx == (lat_passes - PASS_W'(1)));

    always_comb begin
        state_nxt      = state;
        pix_cnt_nxt    = pix_cnt;
        lat_pixels_nxt = lat_pixels;
        pass_idx_nxt   = pass_idx;
        lat_passes_nxt = lat_passes;
        scale_nxt      = scale_q;
        drain_cnt_nxt  = drain_cnt;

        case (state)
            IDLE: begin
                if (sif.start) begin
                    lat_pixels_nxt = sif.cfg_pixels;
                    lat_passes_nxt = sif.cfg_passes;
                    scale_nxt      = sif.cfg_scale;
                    pass_idx_nxt   = '0;
                    pix_cnt_nxt    = '0;
                    // An empty job still reports completion so the layer FSM never stalls.
                    if ((sif.cfg_pixels == '0) || (sif.cfg_passes == '0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD_W;
                    end
                end
            end

            LOAD_W: begin
                if (sif.wgt_ack) begin
                    state_nxt = STREAM;
                end
            end

            STREAM: begin
                if (sif.data_valid_in) begin
                    if (pix_last) begin
                        pix_cnt_nxt = '0;
                        if (pass_last) begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = DRAIN_LOAD;
                        end else begin
                            pass_idx_nxt = pass_idx + PASS_W'(1);
                            state_nxt    = LOAD_W;
                        end
                    end else begin
                        pix_cnt_nxt = pix_cnt + PIX_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            lat_pixels <= '0;
            pass_idx   <= '0;
            lat_passes <= '0;
            scale_q    <= '0;
            drain_cnt  <= '0;
            wgt_req_q  <= 1'b0;
            data_req_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pix_cnt    <= pix_cnt_nxt;
            lat_pixels <= lat_pixels_nxt;
            pass_idx   <= pass_idx_nxt;
            lat_passes <= lat_passes_nxt;
            scale_q    <= scale_nxt;
            drain_cnt  <= drain_cnt_nxt;
            // Request strobes come straight from flops so the datapath sees clean edges.
            wgt_req_q  <= (state_nxt == LOAD_W);
            data_req_q <= (state_nxt == STREAM);
        end
    end

    assign sif.wgt_req   = wgt_req_q;
    assign sif.data_req  = data_req_q;
    assign sif.busy      = (state != IDLE);
    assign sif.state_end = (state == DONE);
    assign sif.scale_out = scale_q;
    assign sif.pass_idx  = pass_idx;
    assign sif.last_pass = (state != IDLE) && pass_last;
    // First pixel of the job loads the accumulators instead of adding to stale sums.
    assign sif.adder_rst = pix_accept && (pass_idx == '0) && (pix_cnt == '0);
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// tb/tb_conv_pass_scheduler.sv - randomized self-checking bench for conv_pass_scheduler
module tb_conv_pass_scheduler;
    localparam int PIX_W        = 12;
    localparam int PASS_W       = 8;
    localparam int SCALE_WIDTH  = 4;
    localparam int DRAIN_CYCLES = 4;
    localparam int BUDGET       = 3000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    conv_pass_scheduler_if #(.PIX_W(PIX_W), .PASS_W(PASS_W), .SCALE_WIDTH(SCALE_WIDTH)) sif ();

    conv_pass_scheduler #(
        .PIX_W(PIX_W), .PASS_W(PASS_W), .SCALE_WIDTH(SCALE_WIDTH), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .sif  (sif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level reference: what the job is waiting for, how far it has got.
    typedef struct {
        bit active;
        bit want_wgt;
        bit streaming;
        bit ending;
        int drain_left;
        int pix_seen;
        int pass_no;
        int n_pix;
        int n_pass;
        int scale;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t s, bit start, int cp, int cn, int cs, bit ack, bit dv);
        model_t r = s;
        if (s.ending) begin
            r.ending = 0;
            r.active = 0;
        end else if (!s.active) begin
            if (start) begin
                r.active   = 1;
                r.n_pix    = cp;
                r.n_pass   = cn;
                r.scale    = cs;
                r.pass_no  = 0;
                r.pix_seen = 0;
                if (cp == 0 || cn == 0) r.ending = 1;
                else                    r.want_wgt = 1;
            end
        end else if (s.want_wgt) begin
            if (ack) begin
                r.want_wgt  = 0;
                r.streaming = 1;
            end
        end else if (s.streaming) begin
            if (dv) begin
                if (s.pix_seen == s.n_pix - 1) begin
                    r.pix_seen  = 0;
                    r.streaming = 0;
                    if (s.pass_no == s.n_pass - 1) r.drain_left = DRAIN_CYCLES;
                    else begin
                        r.pass_no  = s.pass_no + 1;
                        r.want_wgt = 1;
                    end
                end else begin
                    r.pix_seen = s.pix_seen + 1;
                end
            end
        end else if (s.drain_left > 0) begin
            r.drain_left = s.drain_left - 1;
            if (r.drain_left == 0) r.ending = 1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '{default: 0};
        else m <= model_step(m, sif.start, int'(sif.cfg_pixels), int'(sif.cfg_passes),
                             int'(sif.cfg_scale), sif.wgt_ack, sif.data_valid_in);
    end

    always @(negedge clk) begin
        check("busy",      32'(sif.busy),      32'(m.active));
        check("wgt_req",   32'(sif.wgt_req),   32'(m.active && m.want_wgt));
        check("data_req",  32'(sif.data_req),  32'(m.active && m.streaming));
        check("adder_rst", 32'(sif.adder_rst),
              32'(m.streaming && sif.data_valid_in && m.pass_no == 0 && m.pix_seen == 0));
        check("scale_out", 32'(sif.scale_out), 32'(m.scale));
        check("pass_idx",  32'(sif.pass_idx),  32'(m.pass_no));
        check("last_pass", 32'(sif.last_pass), 32'(m.active && (m.pass_no == ((m.n_pass - 1) & 255))));
        check("state_end", 32'(sif.state_end), 32'(m.ending));
    end

    int lat, n_wreq, n_adr, n_dreq, n_acc, n_last, n_drain, adr_cyc;

    task automatic run_job(input int pix, input int pas, input int scl, input int k, input int vmode,
                           input logic [5:0] pat, input bit noise, input int abort_pass);
        int  cyc  = 1;
        int  wcnt = 0;
        int  j    = 0;
        bit  prev_wreq = 0;
        lat = -1; n_wreq = 0; n_adr = 0; n_dreq = 0; n_acc = 0; n_last = 0; n_drain = 0; adr_cyc = -1;
        @(posedge clk); #1;
        sif.start         = 1'b1;
        sif.cfg_pixels    = PIX_W'(pix);
        sif.cfg_passes    = PASS_W'(pas);
        sif.cfg_scale     = SCALE_WIDTH'(scl);
        sif.wgt_ack       = 1'b0;
        sif.data_valid_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            sif.start      = noise && sif.busy && ($urandom_range(0, 3) == 0);
            sif.cfg_pixels = PIX_W'($urandom);
            sif.cfg_passes = PASS_W'($urandom);
            sif.cfg_scale  = SCALE_WIDTH'($urandom);
            if (sif.wgt_req) begin
                sif.wgt_ack = (wcnt == k);
                wcnt++;
            end else begin
                wcnt = 0;
                sif.wgt_ack = noise && ($urandom_range(0, 1) == 1);
            end
            if (sif.wgt_req && !prev_wreq) n_wreq++;
            prev_wreq = sif.wgt_req;
            if (sif.data_req) begin
                if (vmode == 0)      sif.data_valid_in = 1'b1;
                else if (vmode == 1) sif.data_valid_in = (j < 6) ? pat[j] : 1'b1;
                else                 sif.data_valid_in = ($urandom_range(0, 1) == 1);
                j++;
                n_dreq++;
                if (sif.data_valid_in) n_acc++;
            end else begin
                sif.data_valid_in = noise && ($urandom_range(0, 1) == 1);
            end
            #1;
            if (sif.adder_rst) begin
                n_adr++;
                if (adr_cyc < 0) adr_cyc = cyc;
            end
            if (sif.last_pass && !sif.state_end) n_last++;
            if (sif.busy && !sif.wgt_req && !sif.data_req && !sif.state_end) n_drain++;
            if (abort_pass >= 0 && sif.data_req && int'(sif.pass_idx) == abort_pass) begin
                sif.start = 1'b0; sif.wgt_ack = 1'b0; sif.data_valid_in = 1'b0;
                rstn = 1'b0;
                #1;
                check("rst_busy",      32'(sif.busy),      0);
                check("rst_wgt_req",   32'(sif.wgt_req),   0);
                check("rst_data_req",  32'(sif.data_req),  0);
                check("rst_adder_rst", 32'(sif.adder_rst), 0);
                check("rst_scale_out", 32'(sif.scale_out), 0);
                check("rst_pass_idx",  32'(sif.pass_idx),  0);
                check("rst_last_pass", 32'(sif.last_pass), 0);
                @(posedge clk); #1;
                rstn = 1'b1;
                return;
            end
            if (sif.state_end) begin
                lat = cyc;
                sif.start = 1'b0; sif.wgt_ack = 1'b0; sif.data_valid_in = 1'b0;
                return;
            end
            if (cyc > BUDGET) begin
                vectors++;
                miscompares++;
                $display("FAIL job_timeout: no state_end after %0d cycles", cyc);
                return;
            end
        end
    endtask

    function automatic int exp_latency(int n, int p, int k);
        if (n == 0 || p == 0) return 2;
        return 1 + p * (k + 1 + n) + DRAIN_CYCLES + 1;
    endfunction

    initial begin
        sif.start = 1'b0; sif.cfg_pixels = '0; sif.cfg_passes = '0; sif.cfg_scale = '0;
        sif.wgt_ack = 1'b0; sif.data_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",      32'(sif.busy),      0);
        check("reset_scale_out", 32'(sif.scale_out), 0);
        check("reset_wgt_req",   32'(sif.wgt_req),   0);
        check("reset_state_end", 32'(sif.state_end), 0);
        rstn = 1'b1;

        run_job(4, 2, 5, 2, 0, 6'b0, 0, -1);
        check("basic_latency",   lat,    20);
        check("basic_wgt_req",   n_wreq, 2);
        check("basic_adder_rst", n_adr,  1);
        check("basic_adr_cycle", adr_cyc, 5);
        check("basic_last_pass", n_last, 11);
        check("basic_scale",     32'(sif.scale_out), 5);

        run_job(3, 1, 2, 0, 1, 6'b101001, 0, -1);
        check("bubble_data_req", n_dreq, 6);
        check("bubble_accepted", n_acc,  3);
        check("bubble_drain",    n_drain, 4);
        check("bubble_latency",  lat,    13);

        run_job(5, 0, 3, 1, 0, 6'b0, 0, -1);
        check("zero_pass_latency",  lat,    2);
        check("zero_pass_wgt_req",  n_wreq, 0);
        check("zero_pass_data_req", n_dreq, 0);
        run_job(0, 3, 3, 1, 0, 6'b0, 0, -1);
        check("zero_pix_latency",  lat,    2);
        check("zero_pix_wgt_req",  n_wreq, 0);
        check("zero_pix_data_req", n_dreq, 0);

        run_job(5, 2, 7, 3, 0, 6'b0, 1, -1);
        check("noise_latency", lat, exp_latency(5, 2, 3));

        run_job(6, 3, 4, 1, 0, 6'b0, 0, 1);
        run_job(3, 2, 6, 1, 0, 6'b0, 0, -1);
        check("post_reset_latency",   lat,   16);
        check("post_reset_adder_rst", n_adr, 1);

        run_job(2, 1, 9, 1, 0, 6'b0, 0, -1);
        check("b2b_scale",     32'(sif.scale_out), 9);
        check("b2b_adder_rst", n_adr, 1);
        check("b2b_latency",   lat,   10);

        for (int i = 0; i < 25; i++) begin
            int  n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            int  p  = int'($urandom_range(0, 4));
            int  k  = int'($urandom_range(0, 3));
            int  vm = ($urandom_range(0, 1) == 1) ? 2 : 0;
            bit  nz = ($urandom_range(0, 1) == 1);
            run_job(n, p, int'($urandom_range(0, 15)), k, vm, 6'b0, nz, -1);
            if (vm == 0) check("rand_latency", lat, exp_latency(n, p, k));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv_pass_scheduler.md
Name: conv_pass_scheduler

Overview:
- Sequences one convolution job through the NPU MAC array (MAC_IN_NUM x MAC_OUT_NUM).
- A job is a number of input-channel passes. Each pass is one weight load followed by a stream of pixels.
- The block handshakes weight loading, gates pixel streaming, clears the accumulators at job start, presents the requantise scale, flags the last pass and reports completion.
- It sits between the top-level layer FSM and the conv datapath.

Parameters:
- PIX_W, 12, width of the pixels-per-pass count.
- PASS_W, 8, width of the pass count.
- SCALE_WIDTH, 4, width of the requantise shift.
- DRAIN_CYCLES, 4, cycles to wait after the last pixel for the MAC pipeline to empty (MULT_PIPELINE_STAGE + 2). Must be >= 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- cfg_pixels  in  PIX_W  pixels per pass
- cfg_passes  in  PASS_W  passes per job
- cfg_scale  in  SCALE_WIDTH  requantise shift for this job
- wgt_req  out  1  request a weight load for the current pass
- wgt_ack  in  1  weight load complete; one-cycle pulse
- data_req  out  1  datapath may accept pixels
- data_valid_in  in  1  pixel accepted this cycle; counts only while data_req=1
- adder_rst  out  1  accumulator clear, active-high
- scale_out  out  SCALE_WIDTH  latched scale
- last_pass  out  1  the current pass is the final one
- pass_idx  out  PASS_W  index of the current pass
- busy  out  1  not in IDLE
- state_end  out  1  one-cycle job-done pulse

Behaviour:
- Reset (asynchronous, any state, including mid-job): state=IDLE, counters=0, all outputs=0 including scale_out.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - On start=1, latch cfg_pixels, cfg_passes and cfg_scale; set pass_idx=0 and the pixel count=0.
  - If either latched count is 0, go to DONE. Otherwise go to LOAD_W.
  - start outside IDLE is ignored.
- LOAD_W:
  - wgt_req=1 (registered) while in this state.
  - On wgt_ack, go to STREAM next cycle.
  - wgt_ack in any other state is ignored.
- STREAM:
  - data_req=1.
  - Each data_valid_in increments the pixel count.
  - When data_valid_in arrives with count == cfg_pixels-1:
    - clear the count;
    - if pass_idx == cfg_passes-1, go to DRAIN;
    - else increment pass_idx and go to LOAD_W.
  - data_req drops in the cycle after the last pixel, so no extra pixel is accepted.
- adder_rst:
  - Combinational = (state==STREAM) & data_valid_in & (pass_idx==0) & (count==0).
  - Marks the first pixel of the job so the MAC loads rather than accumulates.
  - Never asserted on later passes.
- last_pass = busy & (pass_idx == latched_passes-1); held through DRAIN.
- DRAIN:
  - Load a down-counter with DRAIN_CYCLES-1 on entry and go to DONE when it reaches 0.
  - The state therefore lasts exactly DRAIN_CYCLES cycles.
- DONE: state_end=1 for exactly one cycle, then IDLE. busy=0 once back in IDLE.
- Latency for P passes, N pixels each, ack k cycles after wgt_req rises, one pixel per cycle:
  - start to state_end = 1 + P*(k+1+N) + DRAIN_CYCLES + 1 cycles.
- Simultaneous events:
  - wgt_ack and data_valid_in in the same cycle: only the one matching the current state counts.
  - start in the same cycle as state_end: ignored, because the block is not yet in IDLE.
- Counter widths are exact. The pixel count is compared against the latched value and never wraps within a legal job.

Test Plan:
- Basic job: cfg_pixels=4, cfg_passes=2, cfg_scale=5, ack 2 cycles after wgt_req, 1 pixel/cycle.
  - -> wgt_req twice.
  - -> adder_rst exactly once, on pixel 0 of pass 0.
  - -> last_pass high from the second wgt_req through DRAIN.
  - -> scale_out=5.
  - -> state_end 1 cycle, 20 cycles after start.
- Bubbly stream: pixels=3, passes=1, data_valid_in pattern 1,0,0,1,0,1 -> data_req drops the cycle after the third valid; exactly 3 pixels counted; DRAIN lasts 4 cycles.
- Zero config: cfg_passes=0 (and separately cfg_pixels=0) -> no wgt_req, no data_req; state_end 2 cycles after start.
- Spurious inputs: wgt_ack in STREAM, data_valid_in in LOAD_W, start while busy -> no state or count change.
- Reset mid-job: rstn low during STREAM of pass 1 -> all outputs 0 immediately; a following start with new cfg runs cleanly from pass_idx=0.
- Back-to-back jobs: start asserted the cycle after IDLE is re-entered, with cfg_scale=9 -> new config latched; adder_rst reasserted on the first pixel.
